// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-and-add multiplier iterating WIDTH cycles through one prefix adder.
`timescale 1ps / 100fs

module adder #(
    parameter int width = 32,
    parameter int DELAY = 50
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             Cin,
    output logic [width-1:0] sum
);
    localparam int L = $clog2(width);
    if (DELAY < 0) begin : g_bad_delay
        $error("adder: DELAY must be non-negative");
    end
    // Kogge-Stone levels: each level doubles the span of its group generate/propagate.
    for (genvar l = 0; l <= L; l++) begin : lv
        logic [width-1:0] g, p;
        if (l == 0) begin : b0
            assign g = A & B;
            assign p = A ^ B;
        end else begin : bn
            localparam int D = 1 << (l - 1);
            assign g = lv[l-1].g | (lv[l-1].p & (lv[l-1].g << D));
            assign p = lv[l-1].p & ~((~lv[l-1].p) << D);
        end
    end
    logic [width-1:0] c;
    logic             unused_cout;
    assign c = {lv[L].g[width-2:0] | (lv[L].p[width-2:0] & {(width-1){Cin}}), Cin};
    assign sum = lv[0].p ^ c;
    assign unused_cout = lv[L].g[width-1] | lv[L].p[width-1];
endmodule

module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int DELAY = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] next_acc;
    adder #(.width(WIDTH + 1), .DELAY(DELAY)) u_adder (
        .A   ({1'b0, acc_hi}),
        .B   (acc_lo[0] ? {1'b0, mcand} : '0),
        .Cin (1'b0),
        .sum (sum)
    );
    // The sum's top bit is the carry-out; shifting it in keeps the exact 2*WIDTH product.
    assign next_acc = {sum, acc_lo[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= a;
                    acc_hi <= '0;
                    acc_lo <= b;
                    count  <= '0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    {acc_hi, acc_lo} <= next_acc;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        product <= next_acc;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
